// File: rtl/ring_buffer_wr_arbiter_pkg.sv
// Shared types and helpers for the ring buffer write-side arbiter.
package ring_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1
    } state_t;

    localparam int MAX_N_REQ = 16;

    // Index width never drops to zero so a 1-port build still has a legal vector.
    function automatic int idx_w(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

    function automatic int cnt_w(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

    function automatic int onehot_to_idx(input logic [MAX_N_REQ-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_N_REQ; i++) begin
            if (oh[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/ring_buffer_wr_arbiter_if.sv
// Producer-side handshake plus ring buffer enqueue pins, bundled for the arbiter.
interface ring_buffer_wr_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    logic [N_REQ-1:0]       req_valid_i;
    logic [N_REQ*WIDTH-1:0] req_data_i;
    logic [N_REQ-1:0]       req_last_i;
    logic [N_REQ-1:0]       req_ready_o;
    logic [N_REQ-1:0]       grant_o;
    logic                   enqueue_o;
    logic [WIDTH-1:0]       data_o;
    logic                   full_i;
    logic                   busy_o;

    modport slave (
        input  req_valid_i, req_data_i, req_last_i, full_i,
        output req_ready_o, grant_o, enqueue_o, data_o, busy_o
    );

    modport master (
        output req_valid_i, req_data_i, req_last_i, full_i,
        input  req_ready_o, grant_o, enqueue_o, data_o, busy_o
    );
endinterface

// File: rtl/ring_buffer_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request after i_rr_ptr, wrapping.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IW-1:0]    i_rr_ptr,
    output logic [N_REQ-1:0] o_pick,
    output logic             o_any_valid
);
    always_comb begin
        int   w_idx;
        logic w_found;
        o_pick      = '0;
        o_any_valid = |i_req;
        w_found     = 1'b0;
        w_idx       = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_idx = (int'(i_rr_ptr) + i) % N_REQ;
            if (!w_found && i_req[w_idx]) begin
                o_pick[w_idx] = 1'b1;
                w_found       = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ring_buffer_wr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one ring buffer enqueue port
// among N_REQ producers; never enqueues while the buffer reports full.
module ring_buffer_wr_arbiter
    import ring_buffer_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    ring_buffer_wr_arbiter_if.slave bus
);
    localparam int IW = idx_w(N_REQ);
    localparam int BW = cnt_w(MAX_BURST);

    state_t           r_state, w_state_nxt;
    logic [N_REQ-1:0] r_grant, w_grant_nxt;
    logic [IW-1:0]    r_rr_ptr, w_rr_ptr_nxt;
    logic [BW-1:0]    r_burst_cnt, w_burst_cnt_nxt;

    logic [N_REQ-1:0] w_pick;
    logic             w_any_valid;
    logic [IW-1:0]    w_gidx;
    logic             w_gvalid, w_glast, w_beat, w_release;
    logic [WIDTH-1:0] w_gdata;

    rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_rr_pick (
        .i_req       (bus.req_valid_i),
        .i_rr_ptr    (r_rr_ptr),
        .o_pick      (w_pick),
        .o_any_valid (w_any_valid)
    );

    assign w_gidx   = IW'(onehot_to_idx(MAX_N_REQ'(r_grant)));
    assign w_gvalid = bus.req_valid_i[w_gidx];
    assign w_glast  = bus.req_last_i[w_gidx];
    assign w_gdata  = bus.req_data_i[w_gidx*WIDTH +: WIDTH];
    assign w_beat   = (r_state == GRANT) && w_gvalid && !bus.full_i;

    // An idle producer is let go at once, but a full buffer only stalls the grant.
    assign w_release = (w_beat && (w_glast || r_burst_cnt == BW'(MAX_BURST - 1)))
                     || ((r_state == GRANT) && !w_gvalid && !bus.full_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_rr_ptr    <= IW'(N_REQ - 1);
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_burst_cnt_nxt = r_burst_cnt;
        case (r_state)
            IDLE: begin
                if (w_any_valid) begin
                    w_state_nxt     = GRANT;
                    w_grant_nxt     = w_pick;
                    w_burst_cnt_nxt = '0;
                end
            end
            GRANT: begin
                if (w_beat) w_burst_cnt_nxt = r_burst_cnt + 1'b1;
                if (w_release) begin
                    w_state_nxt  = IDLE;
                    w_grant_nxt  = '0;
                    w_rr_ptr_nxt = w_gidx;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_comb begin
        bus.req_ready_o = '0;
        bus.enqueue_o   = 1'b0;
        bus.data_o      = '0;
        bus.grant_o     = r_grant;
        bus.busy_o      = (r_state == GRANT);
        if (r_state == GRANT) begin
            bus.req_ready_o[w_gidx] = !bus.full_i;
            bus.enqueue_o           = w_beat;
            if (w_beat) bus.data_o  = w_gdata;
        end
    end

endmodule

// File: tb/tb_ring_buffer_wr_arbiter.sv
// Randomized and directed bench for ring_buffer_wr_arbiter with a queue scoreboard.
module tb_ring_buffer_wr_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ring_buffer_wr_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus();

    ring_buffer_wr_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passed = 0;

    logic [8:0] pq [N][$];          // per-producer beats, bit 8 = last
    logic [W-1:0] sbq [$];          // expected enqueue data, in order
    logic [W-1:0] rb [$];           // behavioural ring buffer (LENGTH=4)
    logic [W-1:0] drained [$];
    int turns [$];
    int tbeats [$];
    int acc_cnt = 0;

    bit m_busy = 0;
    int m_g = 0, m_ptr = N - 1, m_cnt = 0;

    int   full_mode = 0;            // 0 forced, 1 random, 2 from buffer occupancy
    logic full_force = 1'b0;
    bit   gap_en = 0, deq_en = 0, rb_ovf = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: who should own the port this cycle and whether a beat moves.
    task automatic model_step();
        logic [N-1:0] v, exp_g, exp_r;
        logic f, exp_e;
        v = bus.req_valid_i; f = bus.full_i;
        exp_g = '0; exp_r = '0; exp_e = 1'b0;
        if (!rst && m_busy) begin
            exp_g[m_g] = 1'b1;
            if (!f) exp_r[m_g] = 1'b1;
            exp_e = v[m_g] & !f;
        end
        chk("grant", bus.grant_o, exp_g);
        chk("ready", bus.req_ready_o, exp_r);
        chk("enqueue", bus.enqueue_o, exp_e);
        chk("busy", bus.busy_o, (!rst && m_busy));
        if (!exp_e) chk("data_zero", bus.data_o, 0);
        if (rst) return;
        if (!m_busy) begin
            for (int i = 1; i <= N; i++) begin
                int p;
                p = (m_ptr + i) % N;
                if (v[p]) begin m_g = p; m_cnt = 0; m_busy = 1; break; end
            end
        end else if (exp_e) begin
            sbq.push_back(bus.req_data_i[m_g*W +: W]);
            m_cnt++;
            if (bus.req_last_i[m_g] || m_cnt == MB) begin m_busy = 0; m_ptr = m_g; end
        end else if (!v[m_g] && !f) begin
            m_busy = 0; m_ptr = m_g;
        end
    endtask

    initial forever begin
        @(negedge clk); #1;
        model_step();
    end

    // Monitor: pops the scoreboard whenever the DUT enqueues, tracks turns.
    initial begin
        logic [N-1:0] prev_g;
        prev_g = '0;
        forever begin
            @(negedge clk); #2;
            if (bus.grant_o != 0 && prev_g == 0) begin
                for (int k = 0; k < N; k++) if (bus.grant_o[k]) turns.push_back(k);
                tbeats.push_back(0);
            end
            prev_g = bus.grant_o;
            if (bus.enqueue_o) begin
                acc_cnt++;
                if (tbeats.size() > 0) tbeats[tbeats.size()-1]++;
                if (sbq.size() == 0) chk("unexpected_beat", 1, 0);
                else chk("data", bus.data_o, sbq.pop_front());
            end
        end
    end

    // Producers and the ring buffer model.
    initial begin
        logic [N-1:0] fire, vv, ll;
        logic [N*W-1:0] dd;
        logic enq_s;
        logic [W-1:0] data_s;
        bus.req_valid_i = '0; bus.req_data_i = '0; bus.req_last_i = '0; bus.full_i = 1'b0;
        forever begin
            @(negedge clk); #2;
            fire   = bus.req_valid_i & bus.req_ready_o;
            enq_s  = bus.enqueue_o;
            data_s = bus.data_o;
            @(posedge clk); #1;
            for (int k = 0; k < N; k++) if (fire[k]) void'(pq[k].pop_front());
            if (deq_en && rb.size() > 0 && $urandom_range(0, 1) == 1) drained.push_back(rb.pop_front());
            if (enq_s && full_mode == 2) rb.push_back(data_s);
            if (rb.size() > 4) rb_ovf = 1;
            for (int k = 0; k < N; k++) begin
                if (pq[k].size() > 0 && !(gap_en && $urandom_range(0, 5) == 0)) begin
                    vv[k] = 1'b1; dd[k*W +: W] = pq[k][0][7:0]; ll[k] = pq[k][0][8];
                end else begin
                    vv[k] = 1'b0; dd[k*W +: W] = W'($urandom); ll[k] = 1'($urandom);
                end
            end
            bus.req_valid_i = vv; bus.req_data_i = dd; bus.req_last_i = ll;
            case (full_mode)
                1:       bus.full_i = ($urandom_range(0, 3) == 0);
                2:       bus.full_i = (rb.size() >= 4);
                default: bus.full_i = full_force;
            endcase
        end
    end

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_grant"}, bus.grant_o, 0);
        chk({tag, "_ready"}, bus.req_ready_o, 0);
        chk({tag, "_enq"}, bus.enqueue_o, 0);
        chk({tag, "_data"}, bus.data_o, 0);
        chk({tag, "_busy"}, bus.busy_o, 0);
    endtask

    task automatic assert_reset();
        @(posedge clk); #3;
        rst = 1'b1;
        m_busy = 0; m_ptr = N - 1;
        turns.delete(); tbeats.delete();
        #1 check_outputs_zero("rst");
    endtask

    task automatic release_reset();
        @(posedge clk); #3;
        rst = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        bit pend;
        n = 0;
        do begin
            @(posedge clk); #2;
            n++;
            pend = m_busy || sbq.size() > 0 || rb.size() > 0;
            for (int k = 0; k < N; k++) if (pq[k].size() > 0) pend = 1;
        end while (pend && n < budget);
        repeat (3) @(posedge clk);
        chk("idle_timeout", pend, 0);
    endtask

    task automatic wait_acc(input int target, input int budget);
        int n;
        n = 0;
        while (acc_cnt < target && n < budget) begin @(posedge clk); #2; n++; end
        chk("acc_timeout", (acc_cnt < target), 0);
    endtask

    initial begin
        int a0, e;
        #1 check_outputs_zero("por");
        release_reset();

        // Single port 2, three beats ending with last.
        pq[2].push_back(9'h0A1); pq[2].push_back(9'h0A2); pq[2].push_back(9'h1A3);
        wait_idle(50);
        chk("p2_turn", (turns.size() > 0) ? turns[0] : -1, 2);
        chk("p2_beats", (tbeats.size() > 0) ? tbeats[0] : -1, 3);

        // All ports continuously valid, no last: rotation with full bursts.
        assert_reset(); release_reset();
        for (int k = 0; k < N; k++) for (int i = 0; i < 8; i++) pq[k].push_back(9'(k*16 + i));
        wait_idle(200);
        chk("rot_turns", turns.size(), 8);
        for (int i = 0; i < turns.size() && i < 8; i++) begin
            chk("rot_port", turns[i], i % N);
            chk("rot_beats", tbeats[i], MB);
        end

        // Port 1 stalled by full for five cycles after beat 2.
        assert_reset(); release_reset();
        a0 = acc_cnt;
        for (int i = 0; i < 4; i++) pq[1].push_back(9'(8'h50 + i));
        wait_acc(a0 + 2, 20);
        full_force = 1'b1;
        repeat (5) @(posedge clk);
        full_force = 1'b0;
        wait_idle(50);
        chk("stall_turns", turns.size(), 1);
        chk("stall_beats", (tbeats.size() > 0) ? tbeats[0] : -1, 4);

        // Port 3 goes idle after one beat; port 0 takes over across the wrap.
        assert_reset(); release_reset();
        pq[3].push_back(9'h033);
        begin
            int n;
            n = 0;
            while (!bus.grant_o[3] && n < 20) begin @(posedge clk); #2; n++; end
            chk("p3_grant_seen", bus.grant_o[3], 1);
        end
        pq[0].push_back(9'h00A); pq[0].push_back(9'h10B);
        wait_idle(50);
        chk("wrap_turns", turns.size(), 2);
        chk("wrap_first", (turns.size() > 0) ? turns[0] : -1, 3);
        chk("wrap_first_beats", (tbeats.size() > 0) ? tbeats[0] : -1, 1);
        chk("wrap_second", (turns.size() > 1) ? turns[1] : -1, 0);

        // Reset during port 2's second beat; port 0 must win afterwards.
        assert_reset(); release_reset();
        a0 = acc_cnt;
        for (int i = 0; i < 4; i++) pq[2].push_back(9'(8'hC0 + i));
        wait_acc(a0 + 1, 20);
        assert_reset();
        pq[0].push_back(9'h1EE);
        release_reset();
        wait_idle(80);
        chk("rst_winner", (turns.size() > 0) ? turns[0] : -1, 0);

        // Randomized traffic with random full and valid gaps.
        full_mode = 1; gap_en = 1;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < N; k++) begin
                int nb;
                nb = $urandom_range(1, 10);
                for (int i = 0; i < nb; i++) pq[k].push_back({1'($urandom_range(0, 3) == 0), 8'($urandom)});
            end
            wait_idle(2000);
        end
        full_mode = 0; gap_en = 0;

        // Integration with a 4-entry non-overwritable ring buffer.
        assert_reset(); release_reset();
        full_mode = 2; deq_en = 0; rb_ovf = 0; drained.delete();
        a0 = acc_cnt;
        for (int p = 0; p < 2; p++) for (int i = 0; i < 6; i++) pq[p].push_back({(i == 5), 8'(p*16 + i)});
        repeat (40) @(posedge clk);
        chk("rb_level", rb.size(), 4);
        chk("rb_accepted", acc_cnt - a0, 4);
        deq_en = 1;
        wait_idle(600);
        deq_en = 0; full_mode = 0;
        chk("rb_overflow", rb_ovf, 0);
        chk("rb_drained", drained.size(), 12);
        for (int p = 0; p < 2; p++) begin
            e = 0;
            for (int i = 0; i < drained.size(); i++) begin
                if (drained[i][7:4] == 4'(p)) begin
                    chk("rb_order", drained[i][3:0], e);
                    e++;
                end
            end
            chk("rb_port_count", e, 6);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $display("%0d/%0d checks passed", passed, checks + 1);
        $fatal(1);
    end
endmodule

// File: doc/ring_buffer_wr_arbiter.md
Name: ring_buffer_wr_arbiter

Overview:
Shares the enqueue side of one ring_buffer instance among N_REQ producers.
- Round-robin grant with bounded bursts (up to MAX_BURST beats per grant).
- Valid/ready handshake toward each producer.
- Drives enqueue/data into the buffer and back-pressures on its full flag, so no beat is ever silently dropped.
- Sits between producer blocks and the buffer's enqueue_i/data_i/full pins; the dequeue side is untouched.

Parameters:
N_REQ, 4, number of producer ports (2..16)
WIDTH, 8, data width; must equal the ring buffer WIDTH
MAX_BURST, 4, max beats per grant before forced release (1..256)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; one clock, reset is asynchronous and active-high
req_valid_i  in  N_REQ  per-port beat valid
req_data_i  in  N_REQ*WIDTH  per-port data, port k at bits [k*WIDTH +: WIDTH]
req_last_i  in  N_REQ  per-port last beat of burst, qualified by valid
req_ready_o  out  N_REQ  per-port accept; beat transfers when valid&ready
grant_o  out  N_REQ  one-hot current grant, all-zero when idle
enqueue_o  out  1  to ring buffer enqueue_i
data_o  out  WIDTH  to ring buffer data_i
full_i  in  1  from ring buffer full
busy_o  out  1  high while in GRANT

Behaviour:
- Reset (async, rst=1) values:
  - state=IDLE, grant_o=0, rr_ptr=N_REQ-1 (port 0 has first priority), burst_cnt=0.
  - req_ready_o=0, enqueue_o=0, data_o=0, busy_o=0.
- Reset asserted mid-burst: burst is abandoned immediately; no enqueue_o while rst=1.
- States: IDLE, GRANT (2-bit encoding from package).
- IDLE:
  - If any req_valid_i is high, select the first valid port searching rr_ptr+1, rr_ptr+2, ... modulo N_REQ.
  - Register the one-hot selection into grant_o, set burst_cnt=0, go to GRANT.
  - No beat transfers in IDLE; req_ready_o=0.
- GRANT, granted port g (all combinational from registered state plus inputs):
  - req_ready_o[g] = ~full_i; other ready bits are 0.
  - enqueue_o = req_valid_i[g] & ~full_i.
  - data_o = req_data_i[g] when enqueue_o, else 0.
- Beat: req_valid_i[g] & ~full_i. On a beat, burst_cnt increments.
- Release from GRANT to IDLE, with rr_ptr<=g and grant_o<=0, on any of:
  - (a) a beat with req_last_i[g]=1;
  - (b) a beat with burst_cnt==MAX_BURST-1;
  - (c) req_valid_i[g]=0 with full_i=0 (producer idle, do not hold the buffer).
- full_i=1 in GRANT: stall. State, grant and burst_cnt hold, and there is no enqueue. There is no timeout.
- Latency:
  - First beat: no earlier than the cycle after valid rises (1 arbitration cycle).
  - Release costs one IDLE bubble cycle before the next grant.
- Fairness: with all ports continuously valid, grants rotate 0,1,2,...,N_REQ-1,0; each port moves at most MAX_BURST beats per turn.
- Ring buffer full semantics: enqueue_o is never asserted while full_i=1. This holds even for an OVERWRITABLE buffer: the arbiter never overwrites.
- Simultaneous dequeue: full_i is taken as presented. A same-cycle dequeue does not unblock the enqueue; it proceeds next cycle.
- Widths:
  - burst_cnt is $clog2(MAX_BURST+1) bits.
  - rr_ptr and the grant index are $clog2(N_REQ) bits, wrapping N_REQ-1 -> 0 (N_REQ need not be a power of 2).
- Invariants: grant_o is one-hot or zero; req_ready_o is a subset of grant_o.

Decomposition:
- Package ring_buffer_pkg:
  - state typedef (IDLE, GRANT);
  - localparams for index and burst-counter widths;
  - onehot-to-index function.
- One sub-module rr_pick:
  - purely combinational round-robin selector;
  - inputs: req vector, rr_ptr; outputs: one-hot pick, any_valid.
  - Reusable by a future dequeue-side scheduler.
- The arbiter top holds the FSM, counters and muxing.

Test Plan:
- Single port 2 valid with 3 beats 0xA1,0xA2,0xA3 (last on 0xA3), full_i=0:
  - grant_o=4'b0100 one cycle after valid;
  - enqueue_o high 3 consecutive cycles with data 0xA1..0xA3;
  - then IDLE, rr_ptr=2.
- All 4 ports valid continuously, no last, MAX_BURST=4:
  - grant sequence 0,1,2,3,0, exactly 4 beats each;
  - one idle cycle between grants; 16 beats per 20 cycles.
- Port 1 granted, full_i=1 for 5 cycles mid-burst after beat 2:
  - enqueue_o=0 and req_ready_o=0 during the stall;
  - grant held; burst resumes with beats 3 and 4, then release.
- Port 3 granted, drops valid after 1 beat with full_i=0:
  - release next cycle;
  - a pending port 0 is granted the following cycle (wrap 3->0).
- Assert rst for 1 cycle during port 2's beat 2:
  - all outputs 0 asynchronously;
  - after release, port 0 wins over port 2 when both are valid.
- Ring buffer integration (LENGTH=4, non-overwritable), 2 ports sending 6 beats each, no dequeue:
  - exactly 4 beats accepted, the rest stalled;
  - draining via dequeue returns the beats in accepted order with none lost.
